typing_round_ctrl: RTL and testbench

//  Round sequencer for the typing game; sits between the PS/2 keyboard receiver and the display/score logic.

---
 rtl/typing_round_ctrl.sv | 163 ++++++++++++++++
 tb/tb_typing_round_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/typing_round_ctrl.sv
// Round sequencer for the typing game: countdown, timed play phase with hit/miss
// counting of PS/2 key events, then held results until the next launch.
`timescale 1ns/1ps
module typing_round_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned ROUND_SEC = 60,
  parameter int unsigned CD_SEC    = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        go,
  input  logic [1:0]  mode_sel,
  input  logic        kb_ready,
  input  logic [7:0]  kb_ascii,
  input  logic [7:0]  target_ascii,
  output logic        kb_start,
  output logic [1:0]  kb_mode,
  output logic        kb_clr,
  output logic        next_target,
  output logic [13:0] hit_count,
  output logic [13:0] miss_count,
  output logic [6:0]  sec_left,
  output logic [1:0]  phase,
  output logic        round_done
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICK_DIV - 1);
  localparam logic [6:0]       ROUND_V   = 7'(ROUND_SEC);
  localparam logic [6:0]       CD_V      = 7'(CD_SEC);
  localparam logic [13:0]      CNT_MAX   = 14'd9999;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CD   = 2'b01;
  localparam logic [1:0] S_PLAY = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       sec_q, sec_d;
  logic [13:0]      hit_q, hit_d, miss_q, miss_d;
  logic [1:0]       mode_q, mode_d;
  logic             clr_q, clr_d, nt_q, nt_d, start_q, done_q;
  logic             rdy_q, rdy_prev_q;
  logic [7:0]       ascii_q;
  logic             tick_s, key_evt_s;

  assign tick_s    = (div_q == DIV_MAX);
  assign key_evt_s = rdy_q & ~rdy_prev_q;

  // Next-state, counter and pulse logic for the round sequencer.
  always_comb begin
    state_d = state_q;
    div_d   = tick_s ? {DIV_W{1'b0}} : div_q + {{(DIV_W-1){1'b0}}, 1'b1};
    sec_d   = sec_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    mode_d  = mode_q;
    clr_d   = 1'b0;
    nt_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        div_d = {DIV_W{1'b0}};
        if (go) begin
          state_d = S_CD;
          mode_d  = mode_sel;
          hit_d   = 14'd0;
          miss_d  = 14'd0;
          sec_d   = CD_V;
          clr_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_CD: begin
        if (tick_s) begin
          if (sec_q <= 7'd1) begin
            state_d = S_PLAY;
            sec_d   = ROUND_V;
            nt_d    = 1'b1;
            div_d   = {DIV_W{1'b0}};
          end else begin
            sec_d = sec_q - 7'd1;
          end
        end else begin
          sec_d = sec_q;
        end
      end
      S_PLAY: begin
        // Events are counted even on the cycle of the final tick.
        if (key_evt_s) begin
          if (ascii_q == target_ascii) begin
            hit_d = (hit_q == CNT_MAX) ? hit_q : hit_q + 14'd1;
            nt_d  = 1'b1;
          end else begin
            miss_d = (miss_q == CNT_MAX) ? miss_q : miss_q + 14'd1;
          end
        end else begin
          hit_d = hit_q;
        end
        if (tick_s) begin
          if (sec_q <= 7'd1) begin
            state_d = S_DONE;
            sec_d   = 7'd0;
            div_d   = {DIV_W{1'b0}};
          end else begin
            sec_d = sec_q - 7'd1;
          end
        end else begin
          sec_d = sec_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = {DIV_W{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q    <= S_IDLE;
      div_q      <= {DIV_W{1'b0}};
      sec_q      <= ROUND_V;
      hit_q      <= 14'd0;
      miss_q     <= 14'd0;
      mode_q     <= 2'b00;
      clr_q      <= 1'b0;
      nt_q       <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
      ascii_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sec_q      <= sec_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      mode_q     <= mode_d;
      clr_q      <= clr_d;
      nt_q       <= nt_d;
      start_q    <= (state_d == S_PLAY);
      done_q     <= (state_d == S_DONE);
      rdy_q      <= kb_ready;
      rdy_prev_q <= rdy_q;
      ascii_q    <= kb_ascii;
    end
  end

  assign kb_start    = start_q;
  assign kb_mode     = mode_q;
  assign kb_clr      = clr_q;
  assign next_target = nt_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign sec_left    = sec_q;
  assign phase       = state_q;
  assign round_done  = done_q;

endmodule

// File: tb/tb_typing_round_ctrl.sv
// Scoreboard bench for typing_round_ctrl: one small-timing instance for the round
// flow and a long-round instance for counter saturation.
`timescale 1ns/1ps
module tb_typing_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, kb_ready;
  logic [1:0]  mode_sel;
  logic [7:0]  kb_ascii, target_ascii;
  logic        kb_start, kb_clr, next_target, round_done;
  logic [1:0]  kb_mode, phase;
  logic [13:0] hit_count, miss_count;
  logic [6:0]  sec_left;

  logic        go2, kb_ready2;
  logic        kb_start2, kb_clr2, next_target2, round_done2;
  logic [1:0]  kb_mode2, phase2;
  logic [13:0] hit_count2, miss_count2;
  logic [6:0]  sec_left2;

  typing_round_ctrl #(.TICK_DIV(4), .ROUND_SEC(3), .CD_SEC(2)) dut (
    .clk(clk), .clrn(rst), .go(go), .mode_sel(mode_sel), .kb_ready(kb_ready),
    .kb_ascii(kb_ascii), .target_ascii(target_ascii), .kb_start(kb_start),
    .kb_mode(kb_mode), .kb_clr(kb_clr), .next_target(next_target),
    .hit_count(hit_count), .miss_count(miss_count), .sec_left(sec_left),
    .phase(phase), .round_done(round_done));

  typing_round_ctrl #(.TICK_DIV(400), .ROUND_SEC(70), .CD_SEC(1)) dut2 (
    .clk(clk), .clrn(rst), .go(go2), .mode_sel(2'b00), .kb_ready(kb_ready2),
    .kb_ascii(8'h61), .target_ascii(8'h61), .kb_start(kb_start2),
    .kb_mode(kb_mode2), .kb_clr(kb_clr2), .next_target(next_target2),
    .hit_count(hit_count2), .miss_count(miss_count2), .sec_left(sec_left2),
    .phase(phase2), .round_done(round_done2));

  typedef struct packed {
    logic [13:0] hit;
    logic [13:0] miss;
    logic        nt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  int nt_cnt = 0;
  int nt_base;
  logic [13:0] m_hit, m_miss;

  always @(negedge clk) if (next_target === 1'b1) nt_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m);
    mode_sel = m;
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  // Drive a key and record the expected counters in the scoreboard.
  task automatic push_key(input logic [7:0] a);
    kb_ascii = a;
    kb_ready = 1'b1;
    if (a == target_ascii) begin
      if (m_hit != 14'd9999) m_hit = m_hit + 14'd1;
      sb_q.push_back('{m_hit, m_miss, 1'b1});
    end else begin
      if (m_miss != 14'd9999) m_miss = m_miss + 14'd1;
      sb_q.push_back('{m_hit, m_miss, 1'b0});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; go2 = 1'b0; kb_ready = 1'b0; kb_ready2 = 1'b0;
    mode_sel = 2'b11; kb_ascii = 8'h00; target_ascii = 8'h61;
    m_hit = 14'd0; m_miss = 14'd0;
    step(2);
    n_cmp++; if (phase !== 2'b00) begin n_bad++; $display("FAIL reset_phase got %b want 00", phase); end
    n_cmp++; if (hit_count !== 14'd0 || miss_count !== 14'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count); end
    n_cmp++; if (sec_left !== 7'd3) begin n_bad++; $display("FAIL reset_sec got %0d want 3", sec_left); end
    n_cmp++; if ({kb_start, kb_clr, next_target, round_done, kb_mode} !== 6'b0) begin n_bad++; $display("FAIL reset_outs got %b want 000000", {kb_start, kb_clr, next_target, round_done, kb_mode}); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_countdown;
    nt_base = nt_cnt;
    launch(2'b10);
    m_hit = 14'd0; m_miss = 14'd0;
    n_cmp++; if (phase !== 2'b01) begin n_bad++; $display("FAIL cd_phase got %b want 01", phase); end
    n_cmp++; if (kb_clr !== 1'b1) begin n_bad++; $display("FAIL cd_clr got %b want 1", kb_clr); end
    n_cmp++; if (sec_left !== 7'd2) begin n_bad++; $display("FAIL cd_sec2 got %0d want 2", sec_left); end
    n_cmp++; if (kb_mode !== 2'b10) begin n_bad++; $display("FAIL cd_mode got %b want 10", kb_mode); end
    mode_sel = 2'b01;
    step(1);
    n_cmp++; if (kb_clr !== 1'b0) begin n_bad++; $display("FAIL cd_clr_once got %b want 0", kb_clr); end
    go = 1'b1; kb_ready = 1'b1; kb_ascii = 8'h61;
    step(1);
    go = 1'b0; kb_ready = 1'b0;
    step(2);
    n_cmp++; if (sec_left !== 7'd1 || phase !== 2'b01) begin n_bad++; $display("FAIL cd_sec1 got %0d/%b want 1/01", sec_left, phase); end
    step(4);
    n_cmp++; if (phase !== 2'b10 || sec_left !== 7'd3) begin n_bad++; $display("FAIL play_entry got %b/%0d want 10/3", phase, sec_left); end
    n_cmp++; if (next_target !== 1'b1 || kb_start !== 1'b1) begin n_bad++; $display("FAIL play_entry_pulse got nt=%b start=%b want 1/1", next_target, kb_start); end
    n_cmp++; if (hit_count !== 14'd0 || kb_mode !== 2'b10) begin n_bad++; $display("FAIL cd_ignore got hit=%0d mode=%b want 0/10", hit_count, kb_mode); end
    step(1);
    n_cmp++; if (nt_cnt - nt_base !== 1) begin n_bad++; $display("FAIL cd_nt_count got %0d want 1", nt_cnt - nt_base); end
  endtask

  task automatic test_hit_hold;
    nt_base = nt_cnt;
    push_key(8'h61);
    step(2);
    e = sb_q.pop_front();
    n_cmp++; if (hit_count !== e.hit || miss_count !== e.miss) begin n_bad++; $display("FAIL hit_counts got %0d/%0d want %0d/%0d", hit_count, miss_count, e.hit, e.miss); end
    n_cmp++; if (next_target !== e.nt) begin n_bad++; $display("FAIL hit_nt got %b want %b", next_target, e.nt); end
    step(3);
    kb_ready = 1'b0;
    n_cmp++; if (hit_count !== m_hit || nt_cnt - nt_base !== 1) begin n_bad++; $display("FAIL hit_once got hit=%0d nt=%0d want %0d/1", hit_count, nt_cnt - nt_base, m_hit); end
  endtask

  task automatic test_miss;
    step(1);
    nt_base = nt_cnt;
    push_key(8'h62);
    step(1);
    kb_ready = 1'b0;
    step(1);
    e = sb_q.pop_front();
    n_cmp++; if (hit_count !== e.hit || miss_count !== e.miss) begin n_bad++; $display("FAIL miss_counts got %0d/%0d want %0d/%0d", hit_count, miss_count, e.hit, e.miss); end
    n_cmp++; if (next_target !== e.nt || nt_cnt - nt_base !== 0) begin n_bad++; $display("FAIL miss_nt got %b/%0d want 0/0", next_target, nt_cnt - nt_base); end
  endtask

  task automatic test_done_hold;
    int k;
    k = 0;
    while (phase !== 2'b11 && k < 20) begin step(1); k++; end
    n_cmp++; if (phase !== 2'b11) begin n_bad++; $display("FAIL done_reach got %b want 11", phase); end
    n_cmp++; if (sec_left !== 7'd0 || kb_start !== 1'b0 || round_done !== 1'b1) begin n_bad++; $display("FAIL done_outs got sec=%0d start=%b done=%b want 0/0/1", sec_left, kb_start, round_done); end
    nt_base = nt_cnt;
    for (int i = 0; i < 2; i++) begin
      kb_ascii = (i == 0) ? 8'h61 : 8'h62;
      kb_ready = 1'b1; step(1); kb_ready = 1'b0; step(2);
    end
    n_cmp++; if (hit_count !== m_hit || miss_count !== m_miss || nt_cnt != nt_base || phase !== 2'b11) begin n_bad++; $display("FAIL done_hold got %0d/%0d nt=%0d ph=%b want %0d/%0d 0 11", hit_count, miss_count, nt_cnt - nt_base, phase, m_hit, m_miss); end
  endtask

  task automatic test_final_tick;
    launch(2'b01);
    m_hit = 14'd0; m_miss = 14'd0;
    n_cmp++; if (phase !== 2'b01 || hit_count !== 14'd0 || miss_count !== 14'd0 || kb_clr !== 1'b1) begin n_bad++; $display("FAIL relaunch got ph=%b %0d/%0d clr=%b want 01 0/0 1", phase, hit_count, miss_count, kb_clr); end
    step(18);
    n_cmp++; if (phase !== 2'b10 || sec_left !== 7'd1) begin n_bad++; $display("FAIL pre_final got %b/%0d want 10/1", phase, sec_left); end
    push_key(8'h61);
    step(1);
    kb_ready = 1'b0;
    step(1);
    e = sb_q.pop_front();
    n_cmp++; if (hit_count !== e.hit || next_target !== e.nt) begin n_bad++; $display("FAIL final_evt got hit=%0d nt=%b want %0d/%b", hit_count, next_target, e.hit, e.nt); end
    n_cmp++; if (phase !== 2'b11 || sec_left !== 7'd0 || kb_start !== 1'b0) begin n_bad++; $display("FAIL final_done got %b/%0d/%b want 11/0/0", phase, sec_left, kb_start); end
  endtask

  task automatic test_reset_mid;
    launch(2'b01);
    m_hit = 14'd0; m_miss = 14'd0;
    step(1);
    mode_sel = 2'b11;
    step(7);
    n_cmp++; if (phase !== 2'b10) begin n_bad++; $display("FAIL mid_play got %b want 10", phase); end
    for (int i = 0; i < 5; i++) begin
      push_key(8'h61);
      step(1);
      kb_ready = 1'b0;
      step(1);
      e = sb_q.pop_front();
      n_cmp++; if (hit_count !== e.hit) begin n_bad++; $display("FAIL mid_hit%0d got %0d want %0d", i, hit_count, e.hit); end
    end
    n_cmp++; if (kb_mode !== 2'b01) begin n_bad++; $display("FAIL mode_stable got %b want 01", kb_mode); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (phase !== 2'b00 || hit_count !== 14'd0 || miss_count !== 14'd0 || kb_start !== 1'b0) begin n_bad++; $display("FAIL mid_reset got ph=%b %0d/%0d start=%b want 00 0/0 0", phase, hit_count, miss_count, kb_start); end
    n_cmp++; if (kb_mode !== 2'b00 || sec_left !== 7'd3) begin n_bad++; $display("FAIL mid_reset_mode got %b/%0d want 00/3", kb_mode, sec_left); end
    rst = 1'b0;
    step(1);
    launch(2'b11);
    n_cmp++; if (kb_mode !== 2'b11) begin n_bad++; $display("FAIL mode_relatch got %b want 11", kb_mode); end
  endtask

  task automatic test_saturation;
    int k;
    go2 = 1'b1; step(1); go2 = 1'b0;
    k = 0;
    while (phase2 !== 2'b10 && k < 1000) begin step(1); k++; end
    n_cmp++; if (phase2 !== 2'b10) begin n_bad++; $display("FAIL sat_play got %b want 10", phase2); end
    for (int i = 0; i < 9998; i++) begin
      kb_ready2 = 1'b1; step(1); kb_ready2 = 1'b0; step(1);
    end
    step(1);
    n_cmp++; if (hit_count2 !== 14'd9998) begin n_bad++; $display("FAIL sat_pre got %0d want 9998", hit_count2); end
    for (int i = 0; i < 3; i++) begin
      kb_ready2 = 1'b1; step(1); kb_ready2 = 1'b0; step(2);
      n_cmp++; if (hit_count2 !== 14'd9999) begin n_bad++; $display("FAIL sat_hold%0d got %0d want 9999", i, hit_count2); end
    end
    n_cmp++; if (miss_count2 !== 14'd0 || phase2 !== 2'b10) begin n_bad++; $display("FAIL sat_misc got miss=%0d ph=%b want 0/10", miss_count2, phase2); end
  endtask

  initial begin
    test_reset;
    test_countdown;
    test_hit_hold;
    test_miss;
    test_done_hold;
    test_final_tick;
    test_reset_mid;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
